// File: rtl/simd_add_seq.sv
// Command-driven sequencer around a 32-bit lane-partitioned add/sub datapath.
// Streams cmd_len operand pairs per command, with per-lane signed saturation and sticky overflow flags.
module simd_add_seq #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_width_i,
    input  logic             cmd_saturate_i,
    input  logic             cmd_sub_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_a_i,
    input  logic [31:0]      in_b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_data_o,
    output logic             out_last_o,
    output logic [3:0]       ovf_sticky_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NBYTES = 4;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [1:0]         width_q, width_d;
    logic               sat_q, sat_d;
    logic               sub_q, sub_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic [NBYTES-1:0]  ovf_q, ovf_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               in_fire, out_fire;
    logic               w8, w16;
    logic [NBYTES-1:0]  lane_lsb, lane_msb;
    logic [DATA_W-1:0]  b_eff, raw_sum, res;
    logic [NBYTES-1:0]  byte_ovf, a_sign;
    logic [BYTE_W:0]    bsum;
    logic               cin, cout;
    logic [1:0]         lane_m;

    // Lane geometry: width 11 behaves as a single 32-bit lane
    assign w8  = (width_q == 2'b00);
    assign w16 = (width_q == 2'b01);

    always_comb begin
        lane_lsb = 4'b0001;
        lane_msb = 4'b1000;
        if (w8) begin
            lane_lsb = 4'b1111;
            lane_msb = 4'b1111;
        end else if (w16) begin
            lane_lsb = 4'b0101;
            lane_msb = 4'b1010;
        end
    end

    // Byte-sliced adder; carry is killed and replaced by the subtract carry-in at each lane LSB
    always_comb begin
        b_eff    = sub_q ? ~in_b_i : in_b_i;
        raw_sum  = '0;
        byte_ovf = '0;
        a_sign   = '0;
        bsum     = '0;
        cin      = 1'b0;
        cout     = 1'b0;
        for (int i = 0; i < NBYTES; i++) begin
            cin  = lane_lsb[i] ? sub_q : cout;
            bsum = 9'({1'b0, in_a_i[BYTE_W*i +: BYTE_W]})
                 + 9'({1'b0, b_eff[BYTE_W*i +: BYTE_W]})
                 + 9'(cin);
            cout = bsum[BYTE_W];
            raw_sum[BYTE_W*i +: BYTE_W] = bsum[BYTE_W-1:0];
            a_sign[i]   = in_a_i[BYTE_W*i + BYTE_W-1];
            byte_ovf[i] = lane_msb[i]
                        & (in_a_i[BYTE_W*i + BYTE_W-1] == b_eff[BYTE_W*i + BYTE_W-1])
                        & (bsum[BYTE_W-1] != in_a_i[BYTE_W*i + BYTE_W-1]);
        end
    end

    // Saturation: each byte follows the overflow/sign of its lane's most significant byte
    always_comb begin
        res    = raw_sum;
        lane_m = 2'b11;
        for (int i = 0; i < NBYTES; i++) begin
            lane_m = w8 ? 2'(i) : (w16 ? (2'(i) | 2'b01) : 2'b11);
            if (sat_q && byte_ovf[lane_m]) begin
                if (a_sign[lane_m]) begin
                    res[BYTE_W*i +: BYTE_W] = lane_msb[i] ? 8'h80 : 8'h00;
                end else begin
                    res[BYTE_W*i +: BYTE_W] = lane_msb[i] ? 8'h7F : 8'hFF;
                end
            end
        end
    end

    // in_ready must see out_ready combinationally so a draining output can reload with no bubble
    assign in_ready_o = (state_q == S_RUN) && (remaining_q != '0)
                        && (!out_valid_q || out_ready_i);
    assign in_fire    = in_valid_i && in_ready_o;
    assign out_fire   = out_valid_q && out_ready_i;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        width_d     = width_q;
        sat_d       = sat_q;
        sub_d       = sub_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        ovf_d       = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    width_d     = cmd_width_i;
                    sat_d       = cmd_saturate_i;
                    sub_d       = cmd_sub_i;
                    remaining_d = cmd_len_i;
                    ovf_d       = '0;
                    state_d     = (cmd_len_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (in_fire && (remaining_q == LEN_W'(1))) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!out_valid_q || (out_fire && out_last_q)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (out_fire) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        if (in_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = res;
            out_last_d  = (remaining_q == LEN_W'(1));
            remaining_d = remaining_q - LEN_W'(1);
            ovf_d       = ovf_q | byte_ovf;
        end

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            width_q     <= 2'b00;
            sat_q       <= 1'b0;
            sub_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            width_q     <= width_d;
            sat_q       <= sat_d;
            sub_q       <= sub_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready_o  = cmd_ready_q;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign out_last_o   = out_last_q;
    assign ovf_sticky_o = ovf_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_simd_add_seq.sv
// Directed bench for simd_add_seq: lane arithmetic, saturation, backpressure, zero-length and reset.
module tb_simd_add_seq;

    localparam int unsigned LEN_W = 8;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [1:0]       cmd_width_i;
    logic             cmd_saturate_i;
    logic             cmd_sub_i;
    logic [LEN_W-1:0] cmd_len_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      in_a_i;
    logic [31:0]      in_b_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [31:0]      out_data_o;
    logic             out_last_o;
    logic [3:0]       ovf_sticky_o;
    logic             busy_o;
    logic             done_o;

    int checks = 0;
    int errors = 0;

    simd_add_seq #(.LEN_W(LEN_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_width_i    (cmd_width_i),
        .cmd_saturate_i (cmd_saturate_i),
        .cmd_sub_i      (cmd_sub_i),
        .cmd_len_i      (cmd_len_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_a_i         (in_a_i),
        .in_b_i         (in_b_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_data_o     (out_data_o),
        .out_last_o     (out_last_o),
        .ovf_sticky_o   (ovf_sticky_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Called at a falling edge; returns at the falling edge after the command is accepted
    task automatic start_cmd(input logic [1:0] w, input logic sat, input logic sub,
                             input logic [LEN_W-1:0] len);
        for (int k = 0; k < 20 && cmd_ready_o !== 1'b1; k++) @(negedge clk_i);
        if (cmd_ready_o !== 1'b1) begin
            checks++; errors++;
            $display("FAIL cmd_ready_timeout: got %b expected 1", cmd_ready_o);
        end
        cmd_width_i = w; cmd_saturate_i = sat; cmd_sub_i = sub; cmd_len_i = len;
        cmd_valid_i = 1'b1;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        #1;
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_o); end
        checks++; if (out_data_o !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 00000000", out_data_o); end
        checks++; if (ovf_sticky_o !== 4'b0000) begin errors++; $display("FAIL reset_ovf: got %b expected 0000", ovf_sticky_o); end
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_single(input string name, input logic [1:0] w, input logic sat,
                               input logic sub, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_data, input logic [3:0] exp_ovf);
        start_cmd(w, sat, sub, LEN_W'(1));
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL %s_busy: got %b expected 1", name, busy_o); end
        in_a_i = a; in_b_i = b; in_valid_i = 1'b1; out_ready_i = 1'b0;
        #1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready_o); end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL %s_out_valid: got %b expected 1", name, out_valid_o); end
        checks++; if (out_data_o !== exp_data) begin errors++; $display("FAIL %s_data: got %h expected %h", name, out_data_o, exp_data); end
        checks++; if (out_last_o !== 1'b1) begin errors++; $display("FAIL %s_last: got %b expected 1", name, out_last_o); end
        checks++; if (ovf_sticky_o !== exp_ovf) begin errors++; $display("FAIL %s_ovf: got %b expected %b", name, ovf_sticky_o, exp_ovf); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL %s_early_done: got %b expected 0", name, done_o); end
        out_ready_i = 1'b1;
        @(negedge clk_i);
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL %s_done: got %b expected 1", name, done_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL %s_drained: got %b expected 0", name, out_valid_o); end
        @(negedge clk_i);
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL %s_done_pulse: got %b expected 0", name, done_o); end
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL %s_cmd_ready: got %b expected 1", name, cmd_ready_o); end
        out_ready_i = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [31:0] ve [4];
        logic [31:0] held;
        int sent = 0;
        int got = 0;
        int stall = 0;
        bit seen = 1'b0;
        va[0] = 32'h01020304; vb[0] = 32'h10101010; ve[0] = 32'h11121314;
        va[1] = 32'h7F000000; vb[1] = 32'h01000000; ve[1] = 32'h80000000;
        va[2] = 32'h00FF0080; vb[2] = 32'h00010080; ve[2] = 32'h00000000;
        va[3] = 32'h12345678; vb[3] = 32'h11111111; ve[3] = 32'h23456789;
        held = 32'h0;
        start_cmd(2'b00, 1'b0, 1'b0, LEN_W'(4));
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (out_valid_o === 1'b1 && !seen) begin
                seen = 1'b1; stall = 3; held = out_data_o;
            end
            out_ready_i = (stall == 0);
            #1;
            if (stall > 0) begin
                checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_stall_in_ready: got %b expected 0", in_ready_o); end
                if (stall < 3) begin
                    checks++; if (out_data_o !== held) begin errors++; $display("FAIL bp_stall_data: got %h expected %h", out_data_o, held); end
                    checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL bp_stall_valid: got %b expected 1", out_valid_o); end
                end
                stall--;
            end else if (out_valid_o === 1'b1) begin
                checks++; if (out_data_o !== ve[got]) begin errors++; $display("FAIL bp_data%0d: got %h expected %h", got, out_data_o, ve[got]); end
                checks++; if (out_last_o !== (got == 3)) begin errors++; $display("FAIL bp_last%0d: got %b expected %b", got, out_last_o, (got == 3)); end
                got++;
            end
            if (sent < 4 && in_ready_o === 1'b1) begin
                in_a_i = va[sent]; in_b_i = vb[sent]; in_valid_i = 1'b1; sent++;
            end else begin
                in_valid_i = 1'b0;
            end
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
        if (got < 4) begin
            checks++; errors++;
            $display("FAIL bp_timeout: got %0d beats expected 4", got);
        end
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL bp_done: got %b expected 1", done_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", out_valid_o); end
        checks++; if (ovf_sticky_o !== 4'b1001) begin errors++; $display("FAIL bp_ovf: got %b expected 1001", ovf_sticky_o); end
        @(negedge clk_i);
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL bp_done_pulse: got %b expected 0", done_o); end
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL bp_cmd_ready: got %b expected 1", cmd_ready_o); end
        out_ready_i = 1'b0;
    endtask

    task automatic test_zero_len();
        start_cmd(2'b00, 1'b0, 1'b0, LEN_W'(0));
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL zl_done: got %b expected 1", done_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL zl_out_valid: got %b expected 0", out_valid_o); end
        checks++; if (ovf_sticky_o !== 4'b0000) begin errors++; $display("FAIL zl_ovf: got %b expected 0000", ovf_sticky_o); end
        checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL zl_cmd_ready_busy: got %b expected 0", cmd_ready_o); end
        @(negedge clk_i);
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL zl_done_pulse: got %b expected 0", done_o); end
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL zl_cmd_ready: got %b expected 1", cmd_ready_o); end
        test_single("zl_next", 2'b01, 1'b1, 1'b0, 32'h7FFF0001, 32'h00017FFF, 32'h7FFF7FFF, 4'b1010);
    endtask

    task automatic test_reset_mid_run();
        start_cmd(2'b00, 1'b0, 1'b0, LEN_W'(3));
        in_a_i = 32'h7F000000; in_b_i = 32'h01000000; in_valid_i = 1'b1; out_ready_i = 1'b0;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b expected 1", out_valid_o); end
        checks++; if (ovf_sticky_o !== 4'b1000) begin errors++; $display("FAIL rst_pre_ovf: got %b expected 1000", ovf_sticky_o); end
        #2 rst_i = 1'b1;
        #1;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy_o); end
        checks++; if (ovf_sticky_o !== 4'b0000) begin errors++; $display("FAIL rst_mid_ovf: got %b expected 0000", ovf_sticky_o); end
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid_cmd_ready: got %b expected 1", cmd_ready_o); end
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready: got %b expected 0", in_ready_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        test_single("rst_next", 2'b00, 1'b1, 1'b0, 32'h7F0180FF, 32'h0101FF01, 32'h7F028000, 4'b1010);
    endtask

    initial begin
        cmd_valid_i = 1'b0; cmd_width_i = 2'b00; cmd_saturate_i = 1'b0; cmd_sub_i = 1'b0;
        cmd_len_i = '0; in_valid_i = 1'b0; in_a_i = '0; in_b_i = '0; out_ready_i = 1'b0;
        test_reset();
        test_single("w8_add_sat",   2'b00, 1'b1, 1'b0, 32'h7F0180FF, 32'h0101FF01, 32'h7F028000, 4'b1010);
        test_single("w8_add_wrap",  2'b00, 1'b0, 1'b0, 32'h7F0180FF, 32'h0101FF01, 32'h80027F00, 4'b1010);
        test_single("w8_carry_kill",2'b00, 1'b0, 1'b0, 32'h000000FF, 32'h00000001, 32'h00000000, 4'b0000);
        test_single("w8_sub",       2'b00, 1'b1, 1'b1, 32'h00000000, 32'h01010101, 32'hFFFFFFFF, 4'b0000);
        test_single("w16_sub_sat",  2'b01, 1'b1, 1'b1, 32'h80000005, 32'h00010007, 32'h8000FFFE, 4'b1000);
        test_single("w32_add_sat",  2'b10, 1'b1, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 4'b1000);
        test_single("w32_add_wrap", 2'b10, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1000);
        test_single("w11_sub_sat",  2'b11, 1'b1, 1'b1, 32'h80000000, 32'h00000001, 32'h80000000, 4'b1000);
        test_backpressure();
        test_zero_len();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/simd_add_seq.md
# simd_add_seq

Command-driven sequencer for the partitioned SIMD add/subtract datapath. Accepts one command (lane width, saturate, add/sub, beat count), streams that many operand pairs through a 32-bit lane-partitioned adder with per-lane signed saturation, and returns results on a registered valid/ready output. It accumulates sticky per-lane overflow flags and pulses `done` at command completion. It sits between the instruction/DMA front end and the result writeback.

## Interface
- `LEN_W`, 8, width of `cmd_len`; maximum beats per command = 2^LEN_W-1
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake
- `cmd_width` in 2: 00 = 4x8-bit lanes, 01 = 2x16-bit, 10 = 1x32-bit, 11 = treated as 10
- `cmd_saturate` in 1: clamp overflowing lanes
- `cmd_sub` in 1: compute a-b instead of a+b
- `cmd_len` in LEN_W: beats in this command (0 allowed)
- `in_valid` in 1 / `in_ready` out 1: operand handshake
- `in_a`, `in_b` in 32: operand words
- `out_valid` out 1 / `out_ready` in 1: result handshake
- `out_data` out 32: result word
- `out_last` out 1: marks final beat of the command
- `ovf_sticky` out 4: OR of lane overflows since last command accept
- `busy` out 1: state != IDLE
- `done` out 1: one-cycle completion pulse

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid`: latch width/saturate/sub, load remaining=`cmd_len`, clear `ovf_sticky`. Go to RUN, or to DONE if `cmd_len`==0.
- RUN: `in_ready` = (remaining>0) && (!`out_valid` || `out_ready`). On input handshake: compute, load output register, set `out_valid`, set `out_last` = (remaining==1), decrement remaining, OR lane overflows into `ovf_sticky`. After the last beat is accepted, go to FLUSH.
- FLUSH: wait for the handshake of the `out_last` beat (or for `out_valid` already low), then go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Arithmetic: two's complement per lane; no carry crosses a lane boundary.
- Subtract: per lane, a + ~b with carry-in 1 at the lane LSB.
- Lane overflow: operand sign bits equal (after inversion of b for sub) and the result sign differs.
- Saturate=1: a positive overflow gives 0x7F / 0x7FFF / 0x7FFFFFFF; a negative overflow gives 0x80 / 0x8000 / 0x80000000.
- Saturate=0: the result wraps. Overflow is still flagged.
- Overflow bit index is the lane's most significant byte:
  - width 00: bits 3..0
  - width 01: bits 3 and 1; bits 2 and 0 stay 0
  - width 10: bit 3 only
- `cmd_*` inputs are ignored outside IDLE.

## Timing
- Reset (asynchronous, immediate): state IDLE; remaining 0; `out_valid`, `out_last`, `out_data`, `ovf_sticky`, `in_ready`, `busy`, `done` = 0; `cmd_ready` = 1.
- Command accept at cycle T: `busy`=1 at T+1; `in_ready` can first be high at T+1.
- Latency: input handshake at cycle T gives `out_valid` at T+1.
- Throughput: 1 beat/cycle while `out_ready`=1.
- Backpressure: while `out_valid` && !`out_ready`, `out_data`/`out_last` hold stable and `in_ready`=0.
- Output handshake and new input handshake in the same cycle: the register reloads with no bubble.
- `done` is high the cycle after the final output handshake. `cmd_ready` is high the cycle after `done`.
- `cmd_len`=0: `done` at T+1 with no output beats, and `ovf_sticky` reads 0.
- `ovf_sticky` is updated on the cycle after each input handshake. It holds after `done` until the next command is accepted.

## Test plan
- Width 00, add, sat=1, len 1, a=0x7F0180FF, b=0x0101FF01 -> `out_data`=0x7F028000, `ovf_sticky`=1010, `out_last`=1, `done` one cycle after handshake. Same with sat=0 -> 0x80027F00, `ovf_sticky`=1010.
- Width 01, sub, sat=1, a=0x80000005, b=0x00010007 -> 0x8000FFFE, `ovf_sticky`=1000.
- Width 10, add, a=0x7FFFFFFF, b=0x00000001: sat=1 -> 0x7FFFFFFF; sat=0 -> 0x80000000. `ovf_sticky`=1000 in both cases.
- Width 00, len 4, `out_ready` held low 3 cycles after the first `out_valid`:
  - `in_ready`=0 and `out_data` stable during the stall.
  - All 4 results arrive in order; `out_last` only on beat 4.
  - `done` one cycle after beat 4 handshake; `cmd_ready`=1 the next cycle.
- `cmd_len`=0 -> `done` pulse at T+1, no `out_valid`, `ovf_sticky`=0000; a back-to-back second command is accepted after `done`.
- Reset asserted mid-RUN with `out_valid`=1 -> same cycle `out_valid`=0, `busy`=0, `ovf_sticky`=0, `cmd_ready`=1. A new command after reset runs correctly.
